// File: rtl/bus_pkg.sv
// Shared constants and types for the 16-bit bus demultiplexer slice.
package bus_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  localparam logic SLOT0 = 1'b0;
  localparam logic SLOT1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/out_slot.sv
// One-entry output register slot with valid/ready drain side and a wrapping drain counter.
module out_slot
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             ready_up,
  output logic [CNT_W-1:0] count,
  output slot_state_t      state
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] count_q;
  logic             valid;
  logic             drain;

  assign valid    = (state_q == SLOT_FULL);
  assign drain    = valid & out_ready;
  // A draining slot can take a new word in the same cycle.
  assign ready_up = ~valid | out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) data_q <= data_in;
      if (drain) count_q <= count_q + CNT_W'(1);
    end
  end

  assign out_data = data_q;
  assign count    = count_q;
  assign state    = state_q;

endmodule

// File: rtl/bus_demux_1to2.sv
// Registered 1-to-2 demultiplexer: steers each accepted word into one of two output slots.
module bus_demux_1to2
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  // Handshake: a word moves on any rising edge where valid and ready are both 1;
  // the offering side holds data stable until then.
  logic        ready_up0, ready_up1;
  logic        accept, load0, load1;
  slot_state_t state0, state1;

  // Only the addressed slot gates acceptance, so a stall on one never blocks the other.
  assign in_ready = ~reset & ((in_sel == SLOT1) ? ready_up1 : ready_up0);
  assign accept   = in_valid & in_ready;
  assign load0    = accept & (in_sel == SLOT0);
  assign load1    = accept & (in_sel == SLOT1);

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0),
    .data_in   (in_data),
    .out_data  (out0_data),
    .out_ready (out0_ready),
    .ready_up  (ready_up0),
    .count     (count0),
    .state     (state0)
  );

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1),
    .data_in   (in_data),
    .out_data  (out1_data),
    .out_ready (out1_ready),
    .ready_up  (ready_up1),
    .count     (count1),
    .state     (state1)
  );

  assign out0_valid = (state0 == SLOT_FULL);
  assign out1_valid = (state1 == SLOT_FULL);

endmodule

// File: tb/tb_bus_demux_1to2.sv
// Directed bench for bus_demux_1to2: driver tasks, per-slot expected queues and a drain monitor.
module tb_bus_demux_1to2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  count0;
  logic [7:0]  count1;

  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Clock / reset
  always #5 clk = ~clk;

  bus_demux_1to2 dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one word, push its expected value on acceptance, return stall cycles.
  task automatic send(input logic [15:0] d, input logic s, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (s) exp1_q.push_back(d);
        else   exp0_q.push_back(d);
        break;
      end
      waited++;
      if (waited >= 20) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: word %0h sel %0d not accepted in %0d cycles", d, s, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every drain handshake pops and compares against its slot's queue.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (out0_valid && out0_ready) begin
        if (exp0_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL slot0_unexpected: got %0h expected nothing", out0_data);
        end else check("slot0_data", {16'h0, out0_data}, {16'h0, exp0_q.pop_front()});
      end
      if (out1_valid && out1_ready) begin
        if (exp1_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL slot1_unexpected: got %0h expected nothing", out1_data);
        end else check("slot1_data", {16'h0, out1_data}, {16'h0, exp1_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Reset then idle, with a word offered during reset.
    reset = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    step(); step();
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_valids", {30'h0, out1_valid, out0_valid}, 32'h0);
    check("rst_data", {out1_data, out0_data}, 32'h0);
    check("rst_counts", {16'h0, count1, count0}, 32'h0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check("post_rst_valids", {30'h0, out1_valid, out0_valid}, 32'h0);
    check("post_rst_data", {out1_data, out0_data}, 32'h0);
    check("post_rst_counts", {16'h0, count1, count0}, 32'h0);

    // Basic routing.
    send(16'h1234, 1'b0, w);
    check("route0_valid", {31'h0, out0_valid}, 32'h1);
    check("route0_data", {16'h0, out0_data}, 32'h1234);
    send(16'hABCD, 1'b1, w);
    check("route1_valid", {31'h0, out1_valid}, 32'h1);
    check("route1_data", {16'h0, out1_data}, 32'hABCD);
    check("route0_drained", {31'h0, out0_valid}, 32'h0);
    check("route_count0", {24'h0, count0}, 32'h1);
    in_valid = 1'b0;
    step();
    check("route_count1", {24'h0, count1}, 32'h1);
    check("route1_hold_data", {16'h0, out1_data}, 32'hABCD);

    // Backpressure isolation.
    out0_ready = 1'b0;
    send(16'h0001, 1'b0, w);
    check("bp_first_stall", w, 0);
    in_valid = 1'b1; in_data = 16'h0002; in_sel = 1'b0;
    #1;
    check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    step();
    check("bp_hold_data", {16'h0, out0_data}, 32'h0001);
    check("bp_hold_valid", {31'h0, out0_valid}, 32'h1);
    send(16'h0003, 1'b1, w);
    check("bp_slot1_no_stall", w, 0);
    check("bp_slot1_data", {16'h0, out1_data}, 32'h0003);
    check("bp_slot0_still_held", {16'h0, out0_data}, 32'h0001);
    out0_ready = 1'b1;
    send(16'h0002, 1'b0, w);
    check("bp_release_data", {16'h0, out0_data}, 32'h0002);
    in_valid = 1'b0;
    step(); step();
    check("bp_count0", {24'h0, count0}, 32'h3);
    check("bp_count1", {24'h0, count1}, 32'h2);

    // Simultaneous drain and load on slot 1.
    out1_ready = 1'b0;
    send(16'h000F, 1'b1, w);
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(16'h0010 + 16'(i), 1'b1, w);
      check("stream_no_stall", w, 0);
    end
    check("stream_count1", {24'h0, count1}, 32'h6);
    in_valid = 1'b0;
    step();
    check("stream_count1_final", {24'h0, count1}, 32'h7);
    check("stream_slot1_empty", {31'h0, out1_valid}, 32'h0);

    // Reset mid-operation with both slots full and stalled.
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(16'hAAAA, 1'b0, w);
    send(16'hBBBB, 1'b1, w);
    reset = 1'b1; in_valid = 1'b1; in_data = 16'hCCCC; in_sel = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    reset = 1'b0; in_valid = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    check("mid_rst_valids", {30'h0, out1_valid, out0_valid}, 32'h0);
    check("mid_rst_data", {out1_data, out0_data}, 32'h0);
    check("mid_rst_counts", {16'h0, count1, count0}, 32'h0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(16'h5A5A, 1'b0, w);
    check("after_rst_data", {16'h0, out0_data}, 32'h5A5A);
    check("after_rst_valid", {31'h0, out0_valid}, 32'h1);
    in_valid = 1'b0;
    step();
    check("after_rst_count0", {24'h0, count0}, 32'h1);

    // Counter wrap on slot 0.
    for (int i = 0; i < 254; i++) send(16'(i), 1'b0, w);
    in_valid = 1'b0;
    step();
    check("wrap_count0_ff", {24'h0, count0}, 32'hFF);
    send(16'hBEEF, 1'b0, w);
    in_valid = 1'b0;
    step();
    check("wrap_count0_zero", {24'h0, count0}, 32'h0);
    check("wrap_count1_unchanged", {24'h0, count1}, 32'h0);

    step();
    check("exp0_empty", exp0_q.size(), 0);
    check("exp1_empty", exp1_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
